// File: rtl/fire_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : fire_controller_if
//  Description : Bundles the raw board inputs and the counter-facing outputs
//                of the fire controller.
//                  trigger, reload, arm : raw, asynchronous board inputs
//                  fire                 : one-cycle shot pulse
//                  enable               : high whenever the state is not IDLE
//                  error                : high while the magazine is EMPTY
//                  ammo[3:0]            : rounds remaining
//                  state[2:0]           : IDLE=0 READY=1 COOLDOWN=2 EMPTY=3
//                                         RELOADING=4
//                master drives the buttons, slave is the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fire_controller_if;
    logic       trigger;
    logic       reload;
    logic       arm;
    logic       fire;
    logic       enable;
    logic       error;
    logic [3:0] ammo;
    logic [2:0] state;

    modport master (
        output trigger, reload, arm,
        input  fire, enable, error, ammo, state
    );

    modport slave (
        input  trigger, reload, arm,
        output fire, enable, error, ammo, state
    );
endinterface
`default_nettype wire

// File: rtl/fire_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fire_controller
//  Description : Conditions raw trigger/reload/arm buttons (2-FF sync plus
//                debounce on trigger and reload), and sequences single-cycle
//                fire pulses with a post-shot cooldown, a magazine count and
//                a timed reload. Dry fire is flagged through error.
//  Ports       : clk    - system clock
//                reset  - asynchronous active-high reset
//                bus    - fire_controller_if.slave (buttons in, status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fire_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COOLDOWN_CYCLES = 10000000,
    parameter int RELOAD_CYCLES   = 50000000,
    parameter int MAG_SIZE        = 6
) (
    input  wire logic            clk,
    input  wire logic            reset,
    fire_controller_if.slave     bus
);

    // Timers are loaded with N-1 and expire on the edge that sees zero,
    // so the state leaves exactly N edges after the load edge.
    localparam logic [25:0] c_deb_last    = 26'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] c_cool_load   = 26'(COOLDOWN_CYCLES - 1);
    localparam logic [25:0] c_reload_load = 26'(RELOAD_CYCLES - 1);
    localparam logic [3:0]  c_mag         = 4'(MAG_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_COOLDOWN  = 3'd2,
        ST_EMPTY     = 3'd3,
        ST_RELOADING = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Arm switch: synchronized only.
    // ------------------------------------------------------------------
    logic r_arm_meta;
    logic r_arm_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_meta <= 1'b0;
            r_arm_sync <= 1'b0;
        end else begin
            r_arm_meta <= bus.arm;
            r_arm_sync <= r_arm_meta;
        end
    end

    // ------------------------------------------------------------------
    // Trigger (bit 0) and reload (bit 1): synchronize, debounce and keep
    // a one-cycle-delayed copy of the debounced value for edge detection.
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_db;
    logic [1:0] w_db_q;

    assign w_raw = {bus.reload, bus.trigger};

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic        r_meta;
        logic        r_sync;
        logic        r_db;
        logic        r_db_q;
        logic [25:0] r_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_db   <= 1'b0;
                r_db_q <= 1'b0;
                r_cnt  <= 26'd0;
            end else begin
                r_meta <= w_raw[gi];
                r_sync <= r_meta;
                r_db_q <= r_db;
                // Count consecutive cycles of disagreement; any agreement
                // (a glitch back to the old value) restarts the count.
                if (r_sync == r_db) begin
                    r_cnt <= 26'd0;
                end else if (r_cnt == c_deb_last) begin
                    r_db  <= r_sync;
                    r_cnt <= 26'd0;
                end else begin
                    r_cnt <= r_cnt + 26'd1;
                end
            end
        end

        assign w_db[gi]   = r_db;
        assign w_db_q[gi] = r_db_q;
    end

    // Events exist for exactly one cycle and are never queued.
    logic w_trig_ev;
    logic w_rel_ev;

    assign w_trig_ev = w_db[0] & ~w_db_q[0];
    assign w_rel_ev  = w_db[1] & ~w_db_q[1];

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered alongside the state.
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_fire;
    logic        r_enable;
    logic        r_error;
    logic [3:0]  r_ammo;
    logic [25:0] r_timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_fire   <= 1'b0;
            r_enable <= 1'b0;
            r_error  <= 1'b0;
            r_ammo   <= c_mag;
            r_timer  <= 26'd0;
        end else begin
            r_fire <= 1'b0;
            if ((r_state != ST_IDLE) && !r_arm_sync) begin
                // Disarm wins over everything; ammo is kept, reload aborted.
                r_state  <= ST_IDLE;
                r_enable <= 1'b0;
                r_error  <= 1'b0;
                r_timer  <= 26'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_arm_sync) begin
                            r_state  <= ST_READY;
                            r_enable <= 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (w_rel_ev && (r_ammo < c_mag)) begin
                            r_state <= ST_RELOADING;
                            r_timer <= c_reload_load;
                        end else if (r_ammo == 4'd0) begin
                            // Only reachable by re-arming with an empty magazine.
                            r_state <= ST_EMPTY;
                            r_error <= 1'b1;
                        end else if (w_trig_ev) begin
                            r_fire  <= 1'b1;
                            r_ammo  <= r_ammo - 4'd1;
                            r_timer <= c_cool_load;
                            r_state <= ST_COOLDOWN;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (r_timer == 26'd0) begin
                            if (r_ammo != 4'd0) begin
                                r_state <= ST_READY;
                            end else begin
                                r_state <= ST_EMPTY;
                                r_error <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer - 26'd1;
                        end
                    end
                    ST_EMPTY: begin
                        if (w_rel_ev) begin
                            r_state <= ST_RELOADING;
                            r_error <= 1'b0;
                            r_timer <= c_reload_load;
                        end
                    end
                    ST_RELOADING: begin
                        if (r_timer == 26'd0) begin
                            r_ammo  <= c_mag;
                            r_state <= ST_READY;
                        end else begin
                            r_timer <= r_timer - 26'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_enable <= 1'b0;
                        r_error  <= 1'b0;
                        r_timer  <= 26'd0;
                    end
                endcase
            end
        end
    end

    assign bus.fire   = r_fire;
    assign bus.enable = r_enable;
    assign bus.error  = r_error;
    assign bus.ammo   = r_ammo;
    assign bus.state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fire_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fire_controller
//  Description : Directed bench for fire_controller with a cycle model built
//                from input history windows and deadline times.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fire_controller;
    localparam int D = 4;
    localparam int C = 8;
    localparam int R = 16;
    localparam int M = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fire_controller_if bus ();

    fire_controller #(
        .DEBOUNCE_CYCLES (D),
        .COOLDOWN_CYCLES (C),
        .RELOAD_CYCLES   (R),
        .MAG_SIZE        (M)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int gcyc   = 0;
    int n_fire = 0;
    int last_fire = -1;
    int n_cool = 0;
    int n_rel  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: raw input history per edge since reset, debounced values
    // derived from "last D synchronized samples all opposite", state kept
    // as a mode plus an absolute deadline edge number.
    // ------------------------------------------------------------------
    logic       hist [0:2][0:4095];
    int         mk = 0;
    logic [1:0] mdb1 = 2'b00;   // debounced after previous edge
    logic [1:0] mdb2 = 2'b00;   // debounced two edges back
    logic [2:0] m_state = 3'd0;
    logic [3:0] m_ammo  = 4'(M);
    logic       m_fire  = 1'b0;
    int         m_deadline = 0;

    function automatic logic hv(input int s, input int i);
        if (i < 1) return 1'b0;
        return hist[s][i];
    endfunction

    task automatic model_edge(input int k);
        logic tev, rev, arm_s, flip;
        tev   = mdb1[0] & ~mdb2[0];
        rev   = mdb1[1] & ~mdb2[1];
        arm_s = hv(2, k - 2);
        for (int s = 0; s < 2; s++) begin
            flip = 1'b1;
            for (int i = 2; i <= D + 1; i++)
                if (hv(s, k - i) == mdb1[s]) flip = 1'b0;
            mdb2[s] = mdb1[s];
            if (flip) mdb1[s] = ~mdb1[s];
        end
        m_fire = 1'b0;
        if (m_state != 3'd0 && !arm_s) begin
            m_state = 3'd0;
        end else begin
            case (m_state)
                3'd0: if (arm_s) m_state = 3'd1;
                3'd1: begin
                    if (rev && m_ammo < 4'(M)) begin
                        m_state = 3'd4; m_deadline = k + R;
                    end else if (m_ammo == 0) begin
                        m_state = 3'd3;
                    end else if (tev) begin
                        m_fire = 1'b1; m_ammo = m_ammo - 1;
                        m_deadline = k + C; m_state = 3'd2;
                    end
                end
                3'd2: if (k == m_deadline) m_state = (m_ammo > 0) ? 3'd1 : 3'd3;
                3'd3: if (rev) begin m_state = 3'd4; m_deadline = k + R; end
                3'd4: if (k == m_deadline) begin m_ammo = 4'(M); m_state = 3'd1; end
                default: m_state = 3'd0;
            endcase
        end
    endtask

    // Compare process: inputs change at negedge+1, so at the negedge the
    // raw inputs are those sampled by the preceding posedge.
    always @(negedge clk) begin
        gcyc++;
        if (reset) begin
            mk = 0; mdb1 = 2'b00; mdb2 = 2'b00;
            m_state = 3'd0; m_ammo = 4'(M); m_fire = 1'b0; m_deadline = 0;
        end else begin
            if (mk < 4095) mk++;
            hist[0][mk] = bus.trigger;
            hist[1][mk] = bus.reload;
            hist[2][mk] = bus.arm;
            model_edge(mk);
        end
        check("outputs{fire,en,err,ammo,state}",
              32'({bus.fire, bus.enable, bus.error, bus.ammo, bus.state}),
              32'({m_fire, (m_state != 3'd0), (m_state == 3'd3), m_ammo, m_state}));
        if (bus.fire === 1'b1) begin n_fire++; last_fire = gcyc; end
        if (bus.state === 3'd2) n_cool++;
        if (bus.state === 3'd4) n_rel++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic shot();
        bus.trigger = 1'b1; step(6);
        bus.trigger = 1'b0; step(20);
    endtask

    int p, f0, c0;

    initial begin
        bus.trigger = 1'b0; bus.reload = 1'b0; bus.arm = 1'b0;
        step(3);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_ammo",  32'(bus.ammo),  32'd3);
        check("reset_flags", 32'({bus.fire, bus.enable, bus.error}), 32'd0);
        reset = 1'b0;
        step(2);

        // Arm: state changes 3 cycles after the first sampling edge.
        bus.arm = 1'b1;
        step(2);
        check("arm_still_idle", 32'(bus.state), 32'd0);
        step(1);
        check("arm_ready", 32'({bus.enable, bus.state}), 32'({1'b1, 3'd1}));

        // Clean shot held 20 cycles.
        c0 = n_cool;
        p = gcyc; bus.trigger = 1'b1; step(20); bus.trigger = 1'b0;
        check("clean_one_fire", 32'(n_fire), 32'd1);
        check("fire_latency", 32'(last_fire - p), 32'd7);
        check("cooldown_len", 32'(n_cool - c0), 32'd8);
        check("after_shot", 32'({bus.ammo, bus.state}), 32'({4'd2, 3'd1}));
        check("model_ammo_pin", 32'(m_ammo), 32'd2);
        step(8);

        // Bouncy trigger never debounces.
        for (int i = 0; i < 10; i++) begin
            bus.trigger = ~bus.trigger; step(2);
        end
        step(8);
        check("bounce_no_fire", 32'(n_fire), 32'd1);

        // Second press lands on the last cooldown cycle and is dropped.
        bus.trigger = 1'b1; step(4); bus.trigger = 1'b0; step(4);
        bus.trigger = 1'b1; step(6); bus.trigger = 1'b0; step(20);
        check("cooldown_drop", 32'(n_fire), 32'd2);
        check("cooldown_ammo", 32'(bus.ammo), 32'd1);

        // Last round: COOLDOWN then EMPTY.
        shot();
        check("empty_state", 32'({bus.error, bus.ammo, bus.state}), 32'({1'b1, 4'd0, 3'd3}));
        bus.trigger = 1'b1; step(6); bus.trigger = 1'b0; step(8);
        check("dry_fire", 32'(n_fire), 32'd3);

        // Re-arm with an empty magazine: READY one cycle, then EMPTY.
        bus.arm = 1'b0; step(4);
        check("disarm_empty", 32'({bus.ammo, bus.state}), 32'({4'd0, 3'd0}));
        bus.arm = 1'b1; step(3);
        check("rearm_ready", 32'(bus.state), 32'd1);
        step(1);
        check("rearm_empty", 32'({bus.error, bus.state}), 32'({1'b1, 3'd3}));

        // Reload from EMPTY.
        c0 = n_rel;
        bus.reload = 1'b1; step(7);
        check("reloading", 32'({bus.error, bus.state}), 32'({1'b0, 3'd4}));
        bus.reload = 1'b0; step(9);
        check("reloading_mid", 32'(bus.state), 32'd4);
        step(8);
        check("reload_done", 32'({bus.error, bus.ammo, bus.state}), 32'({1'b0, 4'd3, 3'd1}));
        check("reload_len", 32'(n_rel - c0), 32'd16);

        // Simultaneous reload and trigger with ammo=2: reload wins.
        shot();
        f0 = n_fire;
        bus.trigger = 1'b1; bus.reload = 1'b1; step(7);
        check("simul_reload", 32'(bus.state), 32'd4);
        check("simul_no_fire", 32'(n_fire), 32'(f0));
        bus.trigger = 1'b0; bus.reload = 1'b0; step(20);
        check("simul_done", 32'({bus.ammo, bus.state}), 32'({4'd3, 3'd1}));

        // Disarm mid-reload: no refill.
        shot();
        bus.reload = 1'b1; step(7);
        check("pre_disarm", 32'(bus.state), 32'd4);
        bus.reload = 1'b0; bus.arm = 1'b0; step(4);
        check("disarm_reload", 32'({bus.enable, bus.ammo, bus.state}), 32'({1'b0, 4'd2, 3'd0}));
        bus.arm = 1'b1; step(3);
        check("rearm_keep_ammo", 32'({bus.ammo, bus.state}), 32'({4'd2, 3'd1}));

        // Async reset during COOLDOWN.
        bus.trigger = 1'b1; step(8);
        check("in_cooldown", 32'({bus.ammo, bus.state}), 32'({4'd1, 3'd2}));
        reset = 1'b1; #1;
        check("async_reset", 32'({bus.fire, bus.enable, bus.error, bus.ammo, bus.state}),
              32'({1'b0, 1'b0, 1'b0, 4'd3, 3'd0}));
        bus.trigger = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        check("post_reset_arm", 32'({bus.ammo, bus.state}), 32'({4'd3, 3'd1}));
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
